// File: rtl/shape_processor_multi_ctrl_if.sv
// Register-bus interface for the shape processor control block:
// write/read strobes, addresses, write data, registered read data and error pulse.
interface shape_processor_multi_ctrl_if #(
  parameter int NUM_CHANNELS = 4
);
  localparam int ADDR_W = $clog2(NUM_CHANNELS + 1);

  logic              write;
  logic [ADDR_W-1:0] write_addr;
  logic [31:0]       write_data;
  logic              read;
  logic [ADDR_W-1:0] read_addr;
  logic [31:0]       read_data;
  logic              error;

  modport master (
    output write, write_addr, write_data, read, read_addr,
    input  read_data, error
  );

  modport slave (
    input  write, write_addr, write_data, read, read_addr,
    output read_data, error
  );
endinterface

// File: rtl/shape_processor_multi_ctrl.sv
// Multi-channel CTRL register file for the shape processor: write validation,
// per-channel START/busy/done sequencing, sticky error STATUS and registered reads.
module shape_processor_multi_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  shape_processor_multi_ctrl_if.slave   bus,
  output logic [NUM_CHANNELS-1:0]       busy,
  output logic [NUM_CHANNELS-1:0]       done
);
  localparam int ADDR_W = $clog2(NUM_CHANNELS + 1);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CHANNELS);

  localparam logic [2:0] SHAPE_CIRCLE    = 3'd0;
  localparam logic [2:0] SHAPE_RECTANGLE = 3'd1;
  localparam logic [2:0] SHAPE_TRIANGLE  = 3'd2;
  localparam logic [2:0] SHAPE_KEEP      = 3'd7;

  localparam logic [2:0] OP_PERIMETER      = 3'd0;
  localparam logic [2:0] OP_AREA           = 3'd1;
  localparam logic [2:0] OP_IS_SQUARE      = 3'd2;
  localparam logic [2:0] OP_IS_EQUILATERAL = 3'd3;
  localparam logic [2:0] OP_IS_ISOSCELES   = 3'd4;
  localparam logic [2:0] OP_KEEP           = 3'd7;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_BUSY = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  function automatic logic pair_legal(input logic [2:0] shape, input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_PERIMETER, OP_AREA:               ok = (shape <= SHAPE_TRIANGLE);
      OP_IS_SQUARE:                        ok = (shape == SHAPE_RECTANGLE);
      OP_IS_EQUILATERAL, OP_IS_ISOSCELES:  ok = (shape == SHAPE_TRIANGLE);
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [NUM_CHANNELS-1:0] busy_vec;
  logic [NUM_CHANNELS-1:0] done_vec;
  logic [NUM_CHANNELS-1:0] sticky_vec;
  logic [NUM_CHANNELS-1:0] reject_vec;
  logic [31:0]             ctrl_rd [NUM_CHANNELS];

  logic        status_wr;
  logic        bad_addr_wr;
  logic        error_reg;
  logic [31:0] read_data_reg;
  logic [31:0] read_data_next;
  logic        unused_wdata;

  assign status_wr    = bus.write && (bus.write_addr == STATUS_ADDR);
  assign bad_addr_wr  = bus.write && (bus.write_addr > STATUS_ADDR);
  assign unused_wdata = ^bus.write_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      ch_state_t        state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [2:0]       shape_reg, shape_next;
      logic [2:0]       op_reg, op_next;
      logic             sticky_reg, sticky_next;
      logic             wr_sel, wr_ok, accept, reject, sticky_clr;
      logic [2:0]       wr_shape, wr_op, eff_shape, eff_op;

      always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        shape_next  = shape_reg;
        op_next     = op_reg;
        accept      = 1'b0;
        reject      = 1'b0;

        wr_sel     = bus.write && (bus.write_addr == ADDR_W'(gi));
        wr_shape   = bus.write_data[2:0];
        wr_op      = bus.write_data[10:8];
        eff_shape  = (wr_shape == SHAPE_KEEP) ? shape_reg : wr_shape;
        eff_op     = (wr_op == OP_KEEP) ? op_reg : wr_op;
        // The DONE cycle still counts as occupied, so a new write lands only after it.
        wr_ok      = (wr_shape <= SHAPE_TRIANGLE || wr_shape == SHAPE_KEEP) &&
                     (wr_op <= OP_IS_ISOSCELES || wr_op == OP_KEEP) &&
                     (state_reg == CH_IDLE) &&
                     pair_legal(eff_shape, eff_op);

        if (wr_sel) begin
          accept = wr_ok;
          reject = !wr_ok;
        end

        if (accept) begin
          shape_next = eff_shape;
          op_next    = eff_op;
        end

        case (state_reg)
          CH_IDLE: begin
            if (accept && bus.write_data[31]) begin
              state_next = CH_BUSY;
              cnt_next   = CNT_W'(LATENCY - 1);
            end
          end
          CH_BUSY: begin
            if (cnt_reg == '0) begin
              state_next = CH_DONE;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
          CH_DONE: state_next = CH_IDLE;
          default: state_next = CH_IDLE;
        endcase

        sticky_clr  = status_wr && bus.write_data[16 + gi];
        sticky_next = (sticky_reg && !sticky_clr) || reject;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg  <= CH_IDLE;
          cnt_reg    <= '0;
          shape_reg  <= SHAPE_CIRCLE;
          op_reg     <= OP_PERIMETER;
          sticky_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          cnt_reg    <= cnt_next;
          shape_reg  <= shape_next;
          op_reg     <= op_next;
          sticky_reg <= sticky_next;
        end
      end

      assign busy_vec[gi]   = (state_reg == CH_BUSY);
      assign done_vec[gi]   = (state_reg == CH_DONE);
      assign sticky_vec[gi] = sticky_reg;
      assign reject_vec[gi] = reject;
      assign ctrl_rd[gi]    = {21'd0, op_reg, 5'd0, shape_reg};
    end
  endgenerate

  // Reads see register contents before any same-cycle write takes effect.
  always_comb begin
    read_data_next = '0;
    if (bus.read_addr == STATUS_ADDR) begin
      read_data_next[NUM_CHANNELS-1:0]  = busy_vec;
      read_data_next[16 +: NUM_CHANNELS] = sticky_vec;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (bus.read_addr == ADDR_W'(i)) begin
          read_data_next = ctrl_rd[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_reg     <= 1'b0;
      read_data_reg <= '0;
    end else begin
      error_reg <= (|reject_vec) || bad_addr_wr;
      if (bus.read) begin
        read_data_reg <= read_data_next;
      end
    end
  end

  assign bus.read_data = read_data_reg;
  assign bus.error     = error_reg;
  assign busy          = busy_vec;
  assign done          = done_vec;
endmodule
